// File: rtl/detector_ready_responder_if.sv
// Trigger/ready handshake bundle between the experiment FSM (master)
// and the detector model (slave), including the detector status outputs.
interface detector_ready_responder_if #(
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned MISS_CNT_W  = 8
);
  logic                   enable;
  logic                   trigger_in;
  logic                   detector_ready;
  logic                   exposing;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic [MISS_CNT_W-1:0]  missed_triggers;
  logic [1:0]             detector_state;

  modport master (
    output enable,
    output trigger_in,
    input  detector_ready,
    input  exposing,
    input  frame_count,
    input  missed_triggers,
    input  detector_state
  );

  modport slave (
    input  enable,
    input  trigger_in,
    output detector_ready,
    output exposing,
    output frame_count,
    output missed_triggers,
    output detector_state
  );
endinterface

// File: rtl/detector_ready_responder.sv
// Detector-side responder for the trigger/ready handshake.
// Each accepted trigger holds the detector busy for EXPOSURE_CYCLES followed
// by READOUT_CYCLES of dead time; accepted frames and triggers arriving while
// busy are counted with saturating counters.
// Optional macro DETECTOR_TRIG_FILTER_EN: a trigger must stay high for
// TRIG_FILTER_CYCLES consecutive cycles before it is recognised.
module detector_ready_responder #(
  parameter int unsigned EXPOSURE_CYCLES    = 20_000,
  parameter int unsigned READOUT_CYCLES     = 1_280_000,
  parameter int unsigned FRAME_CNT_W        = 16,
  parameter int unsigned MISS_CNT_W         = 8,
  parameter int unsigned TRIG_FILTER_CYCLES = 4
) (
  input logic                        clock,
  input logic                        reset_signal,
  detector_ready_responder_if.slave  bus
);

  localparam int unsigned MAX_DUR = (EXPOSURE_CYCLES > READOUT_CYCLES) ?
                                    EXPOSURE_CYCLES : READOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_DUR + 1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    READY    = 2'd1,
    EXPOSE   = 2'd2,
    READOUT  = 2'd3
  } state_t;

  // Elaboration-time parameter sanity checks.
  if (EXPOSURE_CYCLES < 1) begin : g_bad_exposure
    $error("EXPOSURE_CYCLES must be >= 1");
  end
  if (READOUT_CYCLES < 1) begin : g_bad_readout
    $error("READOUT_CYCLES must be >= 1");
  end
  if (TRIG_FILTER_CYCLES < 1) begin : g_bad_filter
    $error("TRIG_FILTER_CYCLES must be >= 1");
  end

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       dur_cnt;
  logic [CNT_W-1:0]       dur_cnt_n;
  logic                   take_frame;
  logic                   miss_trig;
  logic                   trig_edge;
  logic                   ready_q;
  logic                   expose_q;
  logic [FRAME_CNT_W-1:0] frame_q;
  logic [MISS_CNT_W-1:0]  miss_q;

`ifdef DETECTOR_TRIG_FILTER_EN
  localparam int unsigned FILT_W = $clog2(TRIG_FILTER_CYCLES + 1);

  logic [FILT_W-1:0] filt_cnt;

  // Run-length of trigger_in high, saturating so a held trigger qualifies once.
  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      filt_cnt <= '0;
    end else if (!bus.trigger_in) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FILT_W'(TRIG_FILTER_CYCLES)) begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  // Qualified edge fires on the cycle the run reaches TRIG_FILTER_CYCLES.
  assign trig_edge = bus.trigger_in && (filt_cnt == FILT_W'(TRIG_FILTER_CYCLES - 1));
`else
  logic trig_q;

  // Previous trigger level for rising-edge detection.
  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= bus.trigger_in;
    end
  end

  assign trig_edge = bus.trigger_in & ~trig_q;
`endif

  // Next-state and duration-counter decisions for the frame sequence.
  always_comb begin
    state_n    = state;
    dur_cnt_n  = dur_cnt;
    take_frame = 1'b0;
    miss_trig  = 1'b0;
    unique case (state)
      DISABLED: begin
        if (bus.enable) begin
          state_n = READY;
        end
      end
      READY: begin
        // A trigger edge wins over a simultaneous disable.
        if (trig_edge) begin
          state_n    = EXPOSE;
          dur_cnt_n  = CNT_W'(EXPOSURE_CYCLES);
          take_frame = 1'b1;
        end else if (!bus.enable) begin
          state_n = DISABLED;
        end
      end
      EXPOSE: begin
        miss_trig = trig_edge;
        if (dur_cnt == CNT_W'(1)) begin
          state_n   = READOUT;
          dur_cnt_n = CNT_W'(READOUT_CYCLES);
        end else begin
          dur_cnt_n = dur_cnt - CNT_W'(1);
        end
      end
      READOUT: begin
        miss_trig = trig_edge;
        if (dur_cnt == CNT_W'(1)) begin
          state_n   = bus.enable ? READY : DISABLED;
          dur_cnt_n = '0;
        end else begin
          dur_cnt_n = dur_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n   = DISABLED;
        dur_cnt_n = '0;
      end
    endcase
  end

  // State, duration counter, registered status outputs and saturating counters.
  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      state    <= DISABLED;
      dur_cnt  <= '0;
      ready_q  <= 1'b0;
      expose_q <= 1'b0;
      frame_q  <= '0;
      miss_q   <= '0;
    end else begin
      state    <= state_n;
      dur_cnt  <= dur_cnt_n;
      ready_q  <= (state_n == READY);
      expose_q <= (state_n == EXPOSE);
      if (take_frame && (frame_q != '1)) begin
        frame_q <= frame_q + FRAME_CNT_W'(1);
      end
      if (miss_trig && (miss_q != '1)) begin
        miss_q <= miss_q + MISS_CNT_W'(1);
      end
    end
  end

  assign bus.detector_ready  = ready_q;
  assign bus.exposing        = expose_q;
  assign bus.frame_count     = frame_q;
  assign bus.missed_triggers = miss_q;
  assign bus.detector_state  = state;

endmodule
